psram_qspi_device: RTL and testbench
====================================

PSRAM_QSPI_DEVICE -- requirements
Module: psram_qspi_device

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n. clk is the only clock; sck is treated as data.
REQ-002 Parameter ADDR_W, default 24: memory-port address width; must be ≤ 24.
REQ-003 clk  input  1  system clock; all state in this domain.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sck  input  1  serial clock from the controller; sampled.
REQ-006 ce_n  input  1  chip enable from the controller, active low; sampled.
REQ-007 din  input  4  controller-driven data lines; sampled.
REQ-008 dout  output  4  device-driven data lines, returned to the controller.
REQ-009 douten  output  4  dout enables, all bits equal.
REQ-010 mem_addr  output  ADDR_W  byte address of the backing memory.
REQ-011 mem_re  output  1  single-cycle read strobe.
REQ-012 mem_rdata  input  8  read data, valid exactly 1 clk after mem_re.
REQ-013 mem_we  output  1  single-cycle byte write strobe.
REQ-014 mem_wdata  output  8  write byte, valid with mem_we.

Function
REQ-015 sck, ce_n and din SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized sck. Any action caused by a pin edge SHALL occur 3 clk after that edge.
REQ-016 The operating range SHALL be sck high and low phases ≥ 2 clk each; behaviour outside this range is undefined.
REQ-017 Mode-0 timing SHALL apply: inputs are captured on the sck rising edge, and dout changes only on the sck falling edge.
REQ-018 FSM states SHALL be IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-019 IDLE: the synchronized ce_n falling SHALL enter CMD with the bit counter cleared.
REQ-020 CMD: 8 rising edges SHALL capture din[0], MSB first. After the eighth edge: 0xEB enters ADDR (read); 0x38 enters ADDR (write); any other value enters IGNORE.
REQ-021 ADDR: 6 rising edges SHALL capture din[3:0], most significant nibble first, forming a 24-bit address. Address bits above ADDR_W are dropped.
REQ-022 Read: after the sixth ADDR edge the FSM SHALL enter DUMMY for 6 rising edges. On the sixth DUMMY rising edge, mem_re SHALL pulse at the current address.
REQ-023 RDATA: from the first falling edge after DUMMY, douten SHALL be 4'hF. On each falling edge dout SHALL present the next nibble, high nibble first.
REQ-024 RDATA: when a byte's high nibble is presented, the address SHALL increment and mem_re SHALL pulse, so the next byte is ready before its high nibble.
REQ-025 Write: after the sixth ADDR edge the FSM SHALL enter WDATA. Every second rising edge (low nibble) SHALL pulse mem_we with the assembled byte at the current address, then increment the address.
REQ-026 Address increment SHALL wrap modulo 2^ADDR_W unless REQ-031 applies.
REQ-027 ce_n rising (synchronized) in any state SHALL return the FSM to IDLE within 1 clk. douten SHALL drop to 0 in the same clk, and a partially received write byte SHALL be discarded (no mem_we).
REQ-028 mem_re and mem_we SHALL never both be asserted in one clk. At most one strobe SHALL be issued per sck edge.
REQ-029 IGNORE SHALL keep douten at 0 and issue no memory strobes until ce_n rises.

Reset
REQ-030 While rst_n is low: FSM in IDLE; counters, address and shift registers 0; dout=0, douten=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0. Assertion mid-transaction SHALL abort it with no further strobes. After release, the next ce_n falling edge SHALL be required to start a transaction.

Configuration
REQ-031 With macro PSRAM_DEVICE_WRAP1K_EN defined, address increment SHALL wrap within the aligned 1024-byte page: bits [9:0] increment and the upper bits are held. Without it, REQ-026 linear wrap SHALL apply.

Verification
REQ-032 Write 0x38, addr 0x000010, data nibbles 1,2,3,4 -> mem_we at 0x10 with 0x12, then at 0x11 with 0x34.
REQ-033 Read 0xEB, addr 0x000010, memory 0x10=0xA5, 0x11=0x3C -> after 6 dummy edges, dout nibbles A,5,3,C on successive falling edges; douten=F throughout.
REQ-034 Read at 0xFFFFFF, two bytes, macro undefined -> second mem_re at 0x000000. With the macro defined, read at 0x0003FF -> second mem_re at 0x000000.
REQ-035 Write 0x38, addr 0x20, 3 nibbles then ce_n high -> exactly one mem_we (0x20); FSM IDLE; no strobe for the trailing nibble.
REQ-036 Command 0x9F then 20 clocks -> no mem_re/mem_we; douten stays 0. A following 0xEB transaction reads correctly.
REQ-037 rst_n low during RDATA -> dout=0 and douten=0 asynchronously; no strobes until a new ce_n falling edge.

Source files
------------

// File: rtl/psram_qspi_device_if.sv
// Pin and memory-port bundle for psram_qspi_device.
// slave is the device view; master is the controller/memory view.
interface psram_qspi_device_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              sck;
    logic              ce_n;
    logic [3:0]        din;
    logic [3:0]        dout;
    logic [3:0]        douten;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              mem_we;
    logic [7:0]        mem_wdata;

    modport slave (
        input  sck, ce_n, din, mem_rdata,
        output dout, douten, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output sck, ce_n, din, mem_rdata,
        input  dout, douten, mem_addr, mem_re, mem_we, mem_wdata
    );
endinterface

// File: rtl/psram_qspi_device.sv
// QSPI PSRAM device front end: quad read 0xEB / quad write 0x38 onto a byte memory port.
// Define PSRAM_DEVICE_WRAP1K_EN to wrap address increments inside the aligned 1 KiB page.
module psram_qspi_device #(
    parameter int unsigned ADDR_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    psram_qspi_device_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRdata, StWdata, StIgnore
    } state_e;

    localparam logic [23:0] AddrMask = 24'((32'd1 << ADDR_W) - 32'd1);

    function automatic logic [23:0] addr_inc(input logic [23:0] a);
`ifdef PSRAM_DEVICE_WRAP1K_EN
        return {a[23:10], 10'(a[9:0] + 10'd1)} & AddrMask;
`else
        return (a + 24'd1) & AddrMask;
`endif
    endfunction

    logic [1:0] sck_sync;
    logic [1:0] ce_sync;
    logic [3:0] din_meta;
    logic [3:0] din_sync;
    logic       sck_prev;
    logic       ce_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync <= '0;
            ce_sync  <= '0;
            din_meta <= '0;
            din_sync <= '0;
            sck_prev <= 1'b0;
            ce_prev  <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], bus.sck};
            ce_sync  <= {ce_sync[0], bus.ce_n};
            din_meta <= bus.din;
            din_sync <= din_meta;
            sck_prev <= sck_sync[1];
            ce_prev  <= ce_sync[1];
        end
    end

    // Edge flags are valid two clk after the pin edge; acting on them lands on the third.
    logic sck_rise;
    logic sck_fall;
    logic ce_fall;
    logic ce_high;
    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign ce_fall  = ~ce_sync[1] & ce_prev;
    assign ce_high  = ce_sync[1];

    state_e      state;
    logic [2:0]  cnt;
    logic [6:0]  cmd_sr;
    logic [7:0]  cmd_next;
    logic [23:0] addr;
    logic        is_read;
    logic        nib_phase;
    logic [3:0]  wr_hi;
    logic [3:0]  rd_lo;
    logic [7:0]  rd_next;
    logic        rd_pend;
    logic        inc_pend;
    logic [3:0]  dout_r;
    logic [3:0]  douten_r;
    logic        mem_re_r;
    logic        mem_we_r;
    logic [7:0]  mem_wdata_r;

    assign cmd_next = {cmd_sr, din_sync[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            cnt         <= '0;
            cmd_sr      <= '0;
            addr        <= '0;
            is_read     <= 1'b0;
            nib_phase   <= 1'b0;
            wr_hi       <= '0;
            rd_lo       <= '0;
            rd_next     <= '0;
            rd_pend     <= 1'b0;
            inc_pend    <= 1'b0;
            dout_r      <= '0;
            douten_r    <= '0;
            mem_re_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
        end else begin
            mem_re_r <= 1'b0;
            mem_we_r <= 1'b0;
            inc_pend <= 1'b0;
            rd_pend  <= mem_re_r;
            if (rd_pend) rd_next <= bus.mem_rdata;
            // Writes present the current address with the strobe, then advance.
            if (inc_pend) addr <= addr_inc(addr);
            if (state != StIdle && ce_high) begin
                state     <= StIdle;
                cnt       <= '0;
                nib_phase <= 1'b0;
                dout_r    <= '0;
                douten_r  <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (ce_fall) begin
                            state <= StCmd;
                            cnt   <= '0;
                        end
                    end
                    StCmd: begin
                        if (sck_rise) begin
                            cmd_sr <= cmd_next[6:0];
                            cnt    <= cnt + 3'd1;
                            if (cnt == 3'd7) begin
                                cnt <= '0;
                                if (cmd_next == 8'hEB) begin
                                    state   <= StAddr;
                                    is_read <= 1'b1;
                                end else if (cmd_next == 8'h38) begin
                                    state   <= StAddr;
                                    is_read <= 1'b0;
                                end else begin
                                    state <= StIgnore;
                                end
                            end
                        end
                    end
                    StAddr: begin
                        if (sck_rise) begin
                            addr <= {addr[19:0], din_sync} & AddrMask;
                            cnt  <= cnt + 3'd1;
                            if (cnt == 3'd5) begin
                                cnt       <= '0;
                                nib_phase <= 1'b0;
                                state     <= is_read ? StDummy : StWdata;
                            end
                        end
                    end
                    StDummy: begin
                        if (sck_rise) begin
                            cnt <= cnt + 3'd1;
                            if (cnt == 3'd5) begin
                                cnt      <= '0;
                                mem_re_r <= 1'b1;
                                state    <= StRdata;
                            end
                        end
                    end
                    StRdata: begin
                        // Presenting a high nibble also prefetches the following byte.
                        if (sck_fall) begin
                            douten_r <= 4'hF;
                            if (!nib_phase) begin
                                dout_r    <= rd_next[7:4];
                                rd_lo     <= rd_next[3:0];
                                addr      <= addr_inc(addr);
                                mem_re_r  <= 1'b1;
                                nib_phase <= 1'b1;
                            end else begin
                                dout_r    <= rd_lo;
                                nib_phase <= 1'b0;
                            end
                        end
                    end
                    StWdata: begin
                        if (sck_rise) begin
                            if (!nib_phase) begin
                                wr_hi     <= din_sync;
                                nib_phase <= 1'b1;
                            end else begin
                                mem_we_r    <= 1'b1;
                                mem_wdata_r <= {wr_hi, din_sync};
                                inc_pend    <= 1'b1;
                                nib_phase   <= 1'b0;
                            end
                        end
                    end
                    StIgnore: begin
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.dout      = dout_r;
    assign bus.douten    = douten_r;
    assign bus.mem_addr  = addr[ADDR_W-1:0];
    assign bus.mem_re    = mem_re_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_wdata = mem_wdata_r;
endmodule

// File: tb/tb_psram_qspi_device.sv
// Bench for psram_qspi_device: directed vector table, reset corner case, randomized
// transactions checked against a byte-level reference memory.
module tb_psram_qspi_device;
    localparam int unsigned AW = 24;
    localparam int HALF = 5;
    localparam int NV = 8;

    logic clk;
    logic rst_n;

    psram_qspi_device_if #(.ADDR_W(AW)) bus ();
    psram_qspi_device #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    // Backing store driven by the DUT strobes.
    logic [7:0] dmem [0:(1<<24)-1];
    initial begin
        for (int i = 0; i < (1 << 24); i++) dmem[i] = init_byte(i[23:0]);
    end

    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= dmem[bus.mem_addr];
        if (bus.mem_we) dmem[bus.mem_addr] <= bus.mem_wdata;
    end

    logic [23:0] re_log[$];
    logic [23:0] we_a[$];
    logic [7:0]  we_d[$];
    int          both_cnt = 0;

    always @(posedge clk) begin
        if (bus.mem_re) re_log.push_back(bus.mem_addr);
        if (bus.mem_we) begin
            we_a.push_back(bus.mem_addr);
            we_d.push_back(bus.mem_wdata);
        end
        if (bus.mem_re && bus.mem_we) both_cnt++;
    end

    // Reference model: sparse byte memory plus the address-advance rule.
    logic [7:0]  rmem [logic [23:0]];
    logic [23:0] exp_wa[$];
    logic [7:0]  exp_wd[$];

    function automatic logic [23:0] next_addr(input logic [23:0] a);
`ifdef PSRAM_DEVICE_WRAP1K_EN
        return (a & 24'hFFFC00) | ((a + 24'd1) & 24'h0003FF);
`else
        return a + 24'd1;
`endif
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        return rmem.exists(a) ? rmem[a] : init_byte(a);
    endfunction

    int n_chk;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    logic [3:0] tx_nib [64];
    logic [3:0] rx_nib [64];
    logic [3:0] rx_en  [64];

    task automatic model_write(input logic [23:0] a, input int nnib);
        logic [23:0] p;
        p = a;
        exp_wa.delete();
        exp_wd.delete();
        for (int i = 0; i + 1 < nnib; i += 2) begin
            rmem[p] = {tx_nib[i], tx_nib[i+1]};
            exp_wa.push_back(p);
            exp_wd.push_back({tx_nib[i], tx_nib[i+1]});
            p = next_addr(p);
        end
    endtask

    task automatic clear_logs();
        re_log.delete();
        we_a.delete();
        we_d.delete();
    endtask

    // One mode-0 sck period; dq/de are what the controller sees at the rising edge.
    task automatic sck_cycle(input logic [3:0] d, output logic [3:0] dq, output logic [3:0] de);
        @(negedge clk);
        bus.din = d;
        repeat (HALF) @(negedge clk);
        dq = bus.dout;
        de = bus.douten;
        bus.sck = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.sck = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input bit has_addr,
                        input int ndummy, input int ndata);
        logic [3:0] q;
        logic [3:0] e;
        bus.ce_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, cmd[i]}, q, e);
        if (has_addr) for (int i = 5; i >= 0; i--) sck_cycle(addr[4*i +: 4], q, e);
        for (int i = 0; i < ndummy; i++) sck_cycle(4'h0, q, e);
        for (int i = 0; i < ndata; i++) begin
            sck_cycle(tx_nib[i], q, e);
            rx_nib[i] = q;
            rx_en[i]  = e;
        end
        repeat (2) @(negedge clk);
        bus.ce_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    typedef struct {
        int          kind;    // 0 write, 1 read, 2 unsupported command
        logic [7:0]  cmd;
        logic [23:0] addr;
        int          ndata;
        logic [31:0] wnib;
        int          exp_we;
        int          exp_re;
        logic [23:0] exp_a0;
        logic [23:0] exp_a1;
        logic [15:0] exp_d;
        logic [3:0]  exp_en;
    } vec_t;

`ifdef PSRAM_DEVICE_WRAP1K_EN
    localparam logic [23:0] TopA1 = 24'hFFFC00;
    localparam logic [15:0] TopD  = 16'hA559;
    localparam logic [23:0] PgA1  = 24'h000000;
    localparam logic [15:0] PgD   = 16'hA65A;
`else
    localparam logic [23:0] TopA1 = 24'h000000;
    localparam logic [15:0] TopD  = 16'hA55A;
    localparam logic [23:0] PgA1  = 24'h000400;
    localparam logic [15:0] PgD   = 16'hA65E;
`endif

    vec_t vecs [NV];

    initial begin
        logic [3:0]  q;
        logic [3:0]  e;
        logic [3:0]  en_or;
        logic [23:0] a;
        logic [23:0] p;
        logic [7:0]  b;
        int          nb;
        int          nn;
        int          sel;

        n_chk = 0;
        n_pass = 0;
        bus.sck = 1'b0;
        bus.ce_n = 1'b1;
        bus.din = 4'h0;
        bus.mem_rdata = 8'h00;

        vecs[0] = '{0, 8'h38, 24'h000010, 4, 32'h1234_0000, 2, 0, 24'h10, 24'h11, 16'h1234, 4'h0};
        vecs[1] = '{0, 8'h38, 24'h000010, 4, 32'hA53C_0000, 2, 0, 24'h10, 24'h11, 16'hA53C, 4'h0};
        vecs[2] = '{1, 8'hEB, 24'h000010, 4, 32'h0, 0, 4, 24'h10, 24'h11, 16'hA53C, 4'hF};
        vecs[3] = '{0, 8'h38, 24'h000020, 3, 32'h7890_0000, 1, 0, 24'h20, 24'h0, 16'h7800, 4'h0};
        vecs[4] = '{1, 8'hEB, 24'hFFFFFF, 4, 32'h0, 0, 4, 24'hFFFFFF, TopA1, TopD, 4'hF};
        vecs[5] = '{1, 8'hEB, 24'h0003FF, 4, 32'h0, 0, 4, 24'h0003FF, PgA1, PgD, 4'hF};
        vecs[6] = '{2, 8'h9F, 24'h000000, 20, 32'h0, 0, 0, 24'h0, 24'h0, 16'h0, 4'h0};
        vecs[7] = '{1, 8'hEB, 24'h000010, 4, 32'h0, 0, 4, 24'h10, 24'h11, 16'hA53C, 4'hF};

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset dout/douten", {24'h0, bus.dout, bus.douten}, 32'h0);
        check("reset mem_addr", {8'h0, bus.mem_addr}, 32'h0);
        check("reset strobes/wdata", {22'h0, bus.mem_re, bus.mem_we, bus.mem_wdata}, 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < 8; i++) tx_nib[i] = vecs[v].wnib[31-4*i -: 4];
            clear_logs();
            xfer(vecs[v].cmd, vecs[v].addr, vecs[v].kind != 2, (vecs[v].kind == 1) ? 6 : 0,
                 vecs[v].ndata);
            if (vecs[v].kind == 0) model_write(vecs[v].addr, vecs[v].ndata);
            check($sformatf("v%0d we count", v), we_a.size(), vecs[v].exp_we);
            check($sformatf("v%0d re count", v), re_log.size(), vecs[v].exp_re);
            if (vecs[v].exp_we >= 1) begin
                check($sformatf("v%0d we0 addr", v), we_a[0], vecs[v].exp_a0);
                check($sformatf("v%0d we0 data", v), we_d[0], vecs[v].exp_d[15:8]);
            end
            if (vecs[v].exp_we >= 2) begin
                check($sformatf("v%0d we1 addr", v), we_a[1], vecs[v].exp_a1);
                check($sformatf("v%0d we1 data", v), we_d[1], vecs[v].exp_d[7:0]);
            end
            if (vecs[v].exp_re >= 2) begin
                check($sformatf("v%0d re0 addr", v), re_log[0], vecs[v].exp_a0);
                check($sformatf("v%0d re1 addr", v), re_log[1], vecs[v].exp_a1);
            end
            if (vecs[v].kind == 1) begin
                for (int i = 0; i < 4; i++)
                    check($sformatf("v%0d dout nib%0d", v, i), rx_nib[i],
                          vecs[v].exp_d[15-4*i -: 4]);
            end
            for (int i = 0; i < vecs[v].ndata; i++)
                check($sformatf("v%0d douten cyc%0d", v, i), rx_en[i], vecs[v].exp_en);
        end

        // Reset in the middle of a read burst.
        clear_logs();
        bus.ce_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, 1'(8'hEB >> i)}, q, e);
        for (int i = 5; i >= 0; i--) sck_cycle((i == 1) ? 4'h1 : 4'h0, q, e);
        for (int i = 0; i < 6; i++) sck_cycle(4'h0, q, e);
        sck_cycle(4'h0, q, e);
        sck_cycle(4'h0, q, e);
        check("pre-reset douten", e, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset dout/douten", {bus.dout, bus.douten}, 8'h00);
        check("async reset strobes", {bus.mem_re, bus.mem_we}, 2'b00);
        clear_logs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        en_or = 4'h0;
        for (int i = 0; i < 8; i++) begin
            sck_cycle(4'hF, q, e);
            en_or |= e;
        end
        check("post-reset douten", en_or, 4'h0);
        check("post-reset strobes", re_log.size() + we_a.size(), 0);
        bus.ce_n = 1'b1;
        repeat (8) @(negedge clk);
        clear_logs();
        xfer(8'hEB, 24'h000010, 1'b1, 6, 2);
        check("post-reset read hi", rx_nib[0], ref_byte(24'h10) >> 4);
        check("post-reset read lo", rx_nib[1], ref_byte(24'h10) & 8'h0F);

        // Randomized transactions against the reference memory.
        for (int t = 0; t < 32; t++) begin
            sel = $urandom_range(0, 5);
            if (sel == 0) a = 24'hFFFFFC + 24'($urandom_range(0, 3));
            else if (sel == 1) a = 24'h0003FC + 24'($urandom_range(0, 3));
            else a = 24'($urandom_range(0, 47));
            clear_logs();
            if ($urandom_range(0, 1) == 0) begin
                nn = $urandom_range(1, 8);
                for (int i = 0; i < nn; i++) tx_nib[i] = 4'($urandom);
                xfer(8'h38, a, 1'b1, 0, nn);
                model_write(a, nn);
                check($sformatf("rnd%0d we count", t), we_a.size(), exp_wa.size());
                check($sformatf("rnd%0d re count", t), re_log.size(), 0);
                for (int k = 0; k < exp_wa.size(); k++) begin
                    check($sformatf("rnd%0d we%0d addr", t, k), we_a[k], exp_wa[k]);
                    check($sformatf("rnd%0d we%0d data", t, k), we_d[k], exp_wd[k]);
                end
                for (int i = 0; i < nn; i++)
                    check($sformatf("rnd%0d douten cyc%0d", t, i), rx_en[i], 4'h0);
            end else begin
                nb = $urandom_range(1, 4);
                for (int i = 0; i < 2 * nb; i++) tx_nib[i] = 4'h0;
                xfer(8'hEB, a, 1'b1, 6, 2 * nb);
                check($sformatf("rnd%0d re count", t), re_log.size(), nb + 2);
                check($sformatf("rnd%0d we count", t), we_a.size(), 0);
                p = a;
                for (int k = 0; k < nb + 2; k++) begin
                    check($sformatf("rnd%0d re%0d addr", t, k), re_log[k], p);
                    p = next_addr(p);
                end
                p = a;
                for (int k = 0; k < nb; k++) begin
                    b = ref_byte(p);
                    check($sformatf("rnd%0d byte%0d hi", t, k), rx_nib[2*k], b[7:4]);
                    check($sformatf("rnd%0d byte%0d lo", t, k), rx_nib[2*k+1], b[3:0]);
                    p = next_addr(p);
                end
                for (int i = 0; i < 2 * nb; i++)
                    check($sformatf("rnd%0d douten cyc%0d", t, i), rx_en[i], 4'hF);
            end
        end

        check("strobe overlap", both_cnt, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
